// File: rtl/data_mem_pipe.sv
// Y-86 data-memory stage: performs one rmmovq/mrmovq/call/ret/pushq/popq access per request.
// Latency: resp_valid pulses LAT cycles after the accepting edge; one op per LAT+1 cycles.
// Backpressure: req_ready is high only in IDLE; req_valid while not ready is ignored (upstream holds).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid / req_ready   request handshake; fields captured at the accepting edge
//   icode                   instruction code selecting the memory operation
//   valA, valE, valP        store data / address operands, call return address
//   resp_valid              one-cycle pulse qualifying valM and mem_err
//   valM                    loaded word, or the stored word for write ops (held between pulses)
//   mem_err                 completed op addressed beyond DEPTH-1
//   err_sticky              set by any mem_err response, cleared only by reset
//   busy                    a request is in flight
module data_mem_pipe #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 1024,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       icode,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valP,
    output logic             resp_valid,
    output logic [WIDTH-1:0] valM,
    output logic             mem_err,
    output logic             err_sticky,
    output logic             busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [3:0] IC_RMMOVQ = 4'h4;
    localparam logic [3:0] IC_MRMOVQ = 4'h5;
    localparam logic [3:0] IC_CALL   = 4'h8;
    localparam logic [3:0] IC_RET    = 4'h9;
    localparam logic [3:0] IC_PUSHQ  = 4'hA;
    localparam logic [3:0] IC_POPQ   = 4'hB;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [3:0]       r_icode;
    logic [WIDTH-1:0] r_valA;
    logic [WIDTH-1:0] r_valE;
    logic [WIDTH-1:0] r_valP;
    logic             r_resp_valid;
    logic [WIDTH-1:0] r_valM;
    logic             r_mem_err;
    logic             r_err_sticky;

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_use_a;
    logic             w_is_rd;
    logic             w_is_wr;
    logic [WIDTH-1:0] w_addr;
    logic             w_oob;
    logic [AW-1:0]    w_idx;
    logic [WIDTH-1:0] w_wdata;
    logic             w_commit;
    logic             w_we;

    // Stack pops read through the old stack pointer (valA); everything else uses the ALU result.
    assign w_use_a  = (r_icode == IC_RET) || (r_icode == IC_POPQ);
    assign w_is_rd  = (r_icode == IC_MRMOVQ) || w_use_a;
    assign w_is_wr  = (r_icode == IC_RMMOVQ) || (r_icode == IC_CALL) || (r_icode == IC_PUSHQ);
    assign w_addr   = w_use_a ? r_valA : r_valE;
    // Full-width compare so high garbage bits can never alias into a legal word.
    assign w_oob    = (w_addr >= WIDTH'(DEPTH));
    assign w_idx    = w_addr[AW-1:0];
    assign w_wdata  = (r_icode == IC_CALL) ? r_valP : r_valA;
    // r_state is cleared asynchronously, so a reset before the final BUSY edge kills the write.
    assign w_commit = (r_state == S_BUSY) && (r_cnt == 4'd0);
    assign w_we     = w_commit && w_is_wr && !w_oob;

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state == S_BUSY);
    assign resp_valid = r_resp_valid;
    assign valM       = r_valM;
    assign mem_err    = r_mem_err;
    assign err_sticky = r_err_sticky;

    // Storage array carries no reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_icode      <= 4'd0;
            r_valA       <= '0;
            r_valE       <= '0;
            r_valP       <= '0;
            r_resp_valid <= 1'b0;
            r_valM       <= '0;
            r_mem_err    <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_icode <= icode;
                        r_valA  <= valA;
                        r_valE  <= valE;
                        r_valP  <= valP;
                        // Counter reaching zero marks the commit edge, LAT edges after accept.
                        r_cnt   <= 4'(LAT - 1);
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b1;
                        if ((w_is_rd || w_is_wr) && w_oob) begin
                            r_mem_err    <= 1'b1;
                            r_err_sticky <= 1'b1;
                        end else begin
                            r_mem_err <= 1'b0;
                            if (w_is_wr) begin
                                r_valM <= w_wdata;
                            end else if (w_is_rd) begin
                                r_valM <= r_mem[w_idx];
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_pipe.sv
module tb_data_mem_pipe;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   icode = 4'h0;
    logic [W-1:0] valA = '0;
    logic [W-1:0] valE = '0;
    logic [W-1:0] valP = '0;
    logic         req_valid0 = 1'b0;
    logic         req_valid1 = 1'b0;

    logic         rdy0, rv0, err0, stk0, busy0;
    logic [W-1:0] vm0;
    logic         rdy1, rv1, err1, stk1, busy1;
    logic [W-1:0] vm1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int cur = 0;

    logic [W-1:0] mdl0 [1024];
    logic [W-1:0] mdl1 [16];
    logic [W-1:0] mlast [2];
    logic [64:0]  q0 [$];
    logic [64:0]  q1 [$];
    logic [64:0]  e0, e1;

    data_mem_pipe #(.WIDTH(64), .DEPTH(1024), .LAT(2)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(rdy0),
        .icode(icode), .valA(valA), .valE(valE), .valP(valP),
        .resp_valid(rv0), .valM(vm0), .mem_err(err0), .err_sticky(stk0), .busy(busy0)
    );

    data_mem_pipe #(.WIDTH(64), .DEPTH(16), .LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(rdy1),
        .icode(icode), .valA(valA), .valE(valE), .valP(valP),
        .resp_valid(rv1), .valM(vm1), .mem_err(err1), .err_sticky(stk1), .busy(busy1)
    );

    wire s_rdy = (cur == 1) ? rdy1 : rdy0;
    wire s_rv  = (cur == 1) ? rv1  : rv0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboards: every response pops the expectation pushed when its request was driven.
    always @(negedge clk) begin
        if (rv0 === 1'b1) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL u0_unexpected_resp got valM=%h err=%b required no response", vm0, err0);
            end else begin
                e0 = q0.pop_front();
                if ({err0, vm0} !== e0) begin
                    bad++;
                    $display("FAIL u0_resp got err=%b valM=%h required err=%b valM=%h", err0, vm0, e0[64], e0[63:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rv1 === 1'b1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL u1_unexpected_resp got valM=%h err=%b required no response", vm1, err1);
            end else begin
                e1 = q1.pop_front();
                if ({err1, vm1} !== e1) begin
                    bad++;
                    $display("FAIL u1_resp got err=%b valM=%h required err=%b valM=%h", err1, vm1, e1[64], e1[63:0]);
                end
            end
        end
    end

    // Reference behaviour of one op; updates the model memory and the held valM.
    function automatic logic [64:0] model(input int d, input logic [3:0] ic,
                                          input logic [W-1:0] a, input logic [W-1:0] e,
                                          input logic [W-1:0] p);
        logic [W-1:0] addr;
        logic [W-1:0] depth;
        logic         rd, wr;
        addr  = (ic == 4'h9 || ic == 4'hB) ? a : e;
        depth = (d == 1) ? 64'd16 : 64'd1024;
        rd    = (ic == 4'h5 || ic == 4'h9 || ic == 4'hB);
        wr    = (ic == 4'h4 || ic == 4'h8 || ic == 4'hA);
        if ((rd || wr) && addr >= depth) return {1'b1, mlast[d]};
        if (wr) begin
            mlast[d] = (ic == 4'h8) ? p : a;
            if (d == 1) mdl1[addr[3:0]] = mlast[d];
            else        mdl0[addr[9:0]] = mlast[d];
        end else if (rd) begin
            mlast[d] = (d == 1) ? mdl1[addr[3:0]] : mdl0[addr[9:0]];
        end
        return {1'b0, mlast[d]};
    endfunction

    // Drive one request at a negedge, wait (bounded) for its response; returns edges-to-response,
    // negedges with req_ready low, and the cycle stamp of acceptance.
    task automatic op(input int d, input logic [3:0] ic, input logic [W-1:0] a,
                      input logic [W-1:0] e, input logic [W-1:0] p,
                      output int lat, output int low, output int acc);
        cur = d; icode = ic; valA = a; valE = e; valP = p;
        if (d == 1) begin q1.push_back(model(d, ic, a, e, p)); req_valid1 = 1'b1; end
        else        begin q0.push_back(model(d, ic, a, e, p)); req_valid0 = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        lat = 0;
        low = 0;
        while (1) begin
            if (s_rdy !== 1'b1) low++;
            if (s_rv === 1'b1) break;
            if (lat >= 20) begin
                total++; bad++;
                $display("FAIL resp_timeout got no resp_valid after %0d cycles required response", lat);
                break;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 1024; i++) begin u0.r_mem[i] = W'(i); mdl0[i] = W'(i); end
        for (int i = 0; i < 16; i++)   begin u1.r_mem[i] = W'(i); mdl1[i] = W'(i); end
        mlast[0] = '0; mlast[1] = '0;
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL rst_req_ready got %b required 1", rdy0); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rst_busy got %b required 0", busy0); end
        total++; if (rv0 !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got %b required 0", rv0); end
        total++; if (vm0 !== 64'd0) begin bad++; $display("FAIL rst_valM got %h required 0", vm0); end
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL rst_mem_err got %b required 0", err0); end
        total++; if (stk0 !== 1'b0) begin bad++; $display("FAIL rst_err_sticky got %b required 0", stk0); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_latency();
        int lat, low, acc;
        op(0, 4'h5, 0, 64'd5, 0, lat, low, acc);
        total++; if (lat != 2) begin bad++; $display("FAIL rd_latency got %0d required 2", lat); end
        total++; if (low != 2) begin bad++; $display("FAIL rd_ready_low got %0d required 2", low); end
        total++; if (vm0 !== 64'd5) begin bad++; $display("FAIL rd_valM got %h required 5", vm0); end
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL rd_mem_err got %b required 0", err0); end
    endtask

    task automatic test_raw();
        int lat, low, acc;
        op(0, 4'h4, 64'hDEAD, 64'd10, 0, lat, low, acc);
        total++; if (vm0 !== 64'hDEAD) begin bad++; $display("FAIL raw_store_valM got %h required dead", vm0); end
        op(0, 4'h5, 0, 64'd10, 0, lat, low, acc);
        total++; if (vm0 !== 64'hDEAD) begin bad++; $display("FAIL raw_load_valM got %h required dead", vm0); end
    endtask

    task automatic test_call_ret_range();
        int lat, low, acc;
        op(0, 4'h8, 0, 64'd1023, 64'h40, lat, low, acc);
        total++; if (vm0 !== 64'h40) begin bad++; $display("FAIL call_valM got %h required 40", vm0); end
        op(0, 4'h9, 64'd1023, 0, 0, lat, low, acc);
        total++; if (vm0 !== 64'h40) begin bad++; $display("FAIL ret_valM got %h required 40", vm0); end
        op(0, 4'hA, 64'h99, 64'd1024, 0, lat, low, acc);
        total++; if (err0 !== 1'b1) begin bad++; $display("FAIL push_oob_err got %b required 1", err0); end
        total++; if (stk0 !== 1'b1) begin bad++; $display("FAIL push_oob_sticky got %b required 1", stk0); end
        total++; if (vm0 !== 64'h40) begin bad++; $display("FAIL push_oob_valM_held got %h required 40", vm0); end
        op(0, 4'h4, 64'h55, 64'h0000_0100_0000_0005, 0, lat, low, acc);
        total++; if (err0 !== 1'b1) begin bad++; $display("FAIL high_bits_oob_err got %b required 1", err0); end
        op(0, 4'h5, 0, 64'd1023, 0, lat, low, acc);
        total++; if (vm0 !== 64'h40) begin bad++; $display("FAIL mem1023_kept got %h required 40", vm0); end
        total++; if (stk0 !== 1'b1) begin bad++; $display("FAIL sticky_after_ok got %b required 1", stk0); end
        op(0, 4'h5, 0, 64'd5, 0, lat, low, acc);
        total++; if (vm0 !== 64'd5) begin bad++; $display("FAIL oob_no_alias_write got %h required 5", vm0); end
    endtask

    task automatic test_reset_abort();
        int lat, low, acc, seen;
        cur = 0; icode = 4'h4; valE = 64'd20; valA = 64'h77; valP = '0;
        req_valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        mlast[0] = '0; mlast[1] = '0;
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (rv0 !== 1'b0) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL abort_resp got %0d pulses required 0", seen); end
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL abort_ready got %b required 1", rdy0); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL abort_busy got %b required 0", busy0); end
        total++; if (vm0 !== 64'd0) begin bad++; $display("FAIL abort_valM got %h required 0", vm0); end
        total++; if (stk0 !== 1'b0) begin bad++; $display("FAIL abort_sticky got %b required 0", stk0); end
        rst_n = 1'b1;
        @(negedge clk);
        op(0, 4'h5, 0, 64'd20, 0, lat, low, acc);
        total++; if (vm0 !== 64'd20) begin bad++; $display("FAIL abort_no_write got %h required 14", vm0); end
    endtask

    task automatic test_capture_nop();
        int lat, low, acc, n;
        cur = 0; icode = 4'h5; valE = 64'd30; valA = '0; valP = '0;
        q0.push_back(model(0, 4'h5, 0, 64'd30, 0));
        req_valid0 = 1'b1;
        @(posedge clk);
        n = 0;
        while (1) begin
            @(negedge clk);
            if (rv0 === 1'b1) break;
            if (n >= 20) begin
                total++; bad++;
                $display("FAIL capture_timeout got no resp_valid required response");
                break;
            end
            icode = 4'h4; valA = 64'h55; valE = 64'd40 + 64'(n * 8);
            n++;
            @(posedge clk);
        end
        req_valid0 = 1'b0;
        total++; if (vm0 !== 64'd30) begin bad++; $display("FAIL capture_valM got %h required 1e", vm0); end
        @(posedge clk);
        @(negedge clk);
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL capture_no_extra_accept got %b required 1", rdy0); end
        op(0, 4'h0, 64'h1234, 64'd7, 64'd9, lat, low, acc);
        total++; if (lat != 2) begin bad++; $display("FAIL nop_latency got %0d required 2", lat); end
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL nop_err got %b required 0", err0); end
        total++; if (vm0 !== 64'd30) begin bad++; $display("FAIL nop_valM got %h required 1e", vm0); end
        op(0, 4'h5, 0, 64'd40, 0, lat, low, acc);
        total++; if (vm0 !== 64'd40) begin bad++; $display("FAIL busy_inputs_ignored got %h required 28", vm0); end
    endtask

    task automatic test_back_to_back();
        int lat, low, a1, a2;
        op(1, 4'hB, 64'd15, 0, 0, lat, low, a1);
        total++; if (vm1 !== 64'd15) begin bad++; $display("FAIL l1_pop_valM got %h required f", vm1); end
        total++; if (lat != 1) begin bad++; $display("FAIL l1_latency got %0d required 1", lat); end
        op(1, 4'hB, 64'd16, 0, 0, lat, low, a1);
        total++; if (err1 !== 1'b1) begin bad++; $display("FAIL l1_pop_oob got %b required 1", err1); end
        op(1, 4'h4, 64'h33, 64'd3, 0, lat, low, a1);
        op(1, 4'h5, 0, 64'd3, 0, lat, low, a2);
        total++; if (a2 - a1 != 2) begin bad++; $display("FAIL l1_throughput got %0d required 2", a2 - a1); end
        total++; if (vm1 !== 64'h33) begin bad++; $display("FAIL l1_raw got %h required 33", vm1); end
        op(0, 4'h5, 0, 64'd1, 0, lat, low, a1);
        op(0, 4'h5, 0, 64'd2, 0, lat, low, a2);
        total++; if (a2 - a1 != 3) begin bad++; $display("FAIL l2_throughput got %0d required 3", a2 - a1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got simulation still running required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_latency();
        test_raw();
        test_call_ret_range();
        test_reset_abort();
        test_capture_nop();
        test_back_to_back();
        repeat (3) @(negedge clk);
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL pending_expectations got %0d/%0d required 0/0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
